mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: starve_limit_p, default 4, consecutive data grants allowed while fetch waits; used only under MEM_ARB_FAIR_EN.
REQ-002 SHALL have port: clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: if_req_v_i  input  1  fetch read request; held until if_done_o.
REQ-005 SHALL have port: if_addr_i  input  rvga_word  fetch address.
REQ-006 SHALL have port: if_rdata_o  output  rvga_word  fetch read data; valid only with if_done_o.
REQ-007 SHALL have port: if_done_o  output  1  fetch access complete, one-cycle pulse.
REQ-008 SHALL have port: if_stall_v_o  output  1  fetch pending and not completing this cycle.
REQ-009 SHALL have port: dm_req_v_i  input  1  data request; held until dm_done_o.
REQ-010 SHALL have port: dm_we_i  input  1  data write enable.
REQ-011 SHALL have port: dm_wmask_i  input  4  byte write mask.
REQ-012 SHALL have port: dm_addr_i / dm_wdata_i  input  rvga_word each  data address / write data.
REQ-013 SHALL have port: dm_rdata_o  output  rvga_word  data read data; valid only with dm_done_o.
REQ-014 SHALL have port: dm_done_o  output  1  data access complete, one-cycle pulse.
REQ-015 SHALL have ports: mem_req_v_o  output  1; mem_we_o  output  1; mem_wmask_o  output  4; mem_addr_o / mem_wdata_o  output  rvga_word; all registered.
REQ-016 SHALL have ports: mem_rdata_i  input  rvga_word; mem_ack_i  input  1  memory completion, any latency >= 1 cycle.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM.
REQ-018 IDLE: no request -> stay; dm_req_v_i -> BUSY_DM; else if_req_v_i -> BUSY_IF; both -> data wins (default priority).
REQ-019 On grant, SHALL latch granted requester's addr/we/wmask/wdata into mem_* registers and set mem_req_v_o=1 next cycle; fetch grant forces mem_we_o=0, mem_wmask_o=0.
REQ-020 BUSY_x: mem_* outputs SHALL hold stable until mem_ack_i; requester input changes SHALL be ignored.
REQ-021 On mem_ack_i in BUSY_x: x_done_o=1 same cycle (combinational), x_rdata_o=mem_rdata_i, mem_req_v_o=0 next cycle, next state IDLE.
REQ-022 Minimum latency: request in IDLE at cycle t -> mem_req_v_o at t+1 -> done at t+1 if ack at t+1; one IDLE cycle between back-to-back grants.
REQ-023 x_rdata_o SHALL be 0 when x_done_o=0; dm_rdata_o SHALL be 0 for writes.
REQ-024 mem_ack_i in IDLE SHALL be ignored (no done pulse, no state change).
REQ-025 if_stall_v_o = if_req_v_i & ~if_done_o.
REQ-026 Requester dropping req_v while not granted SHALL be harmless; dropping while granted is illegal (not checked).

Reset
REQ-027 rst_i assertion SHALL immediately force IDLE, mem_req_v_o=0, mem_we_o=0, mem_wmask_o=0, mem_addr_o=0, mem_wdata_o=0, starvation counter=0.
REQ-028 While rst_i high: both done outputs 0, both rdata outputs 0; reset mid-access abandons it (later ack ignored per REQ-024).

Configuration
REQ-029 Macro MEM_ARB_FAIR_EN defined: 3-bit-min counter counts consecutive data grants while if_req_v_i=1; at starve_limit_p next IDLE arbitration grants fetch over data; cleared on any fetch grant or when if_req_v_i=0 in IDLE.
REQ-030 Macro undefined: strict data priority, no counter logic.

Structure
REQ-031 SHALL add arb_state_e (IDLE, BUSY_IF, BUSY_DM) to rvga_types; rvga_word reused.
REQ-032 SHALL use sub-module mem_arb_starve for the starvation counter, instantiated only under MEM_ARB_FAIR_EN; registers via existing dff.

Verification
REQ-033 Fetch only: if_addr_i=0x100, ack 2 cycles after mem_req_v_o, mem_rdata_i=0x00000013 -> mem_addr_o=0x100, mem_we_o=0, if_done_o single pulse with if_rdata_o=0x13, if_stall_v_o high until then.
REQ-034 Simultaneous: both request same cycle, dm write addr 0x200 data 0xDEADBEEF mask 0xF -> data served first, fetch next after one IDLE cycle.
REQ-035 Fairness (MEM_ARB_FAIR_EN, limit 4): continuous data + fetch requests -> fetch granted after exactly 4 data grants; without macro fetch never granted.
REQ-036 Reset mid-access: rst_i during BUSY_DM, ack arrives after release -> mem_req_v_o 0 immediately, no dm_done_o.
REQ-037 Stray ack: mem_ack_i pulse in IDLE -> no done, state stays IDLE.

Source files
------------

// File: rtl/rvga_types.sv
// rtl/rvga_types.sv - shared word type and memory arbiter state encoding
package rvga_types;

   typedef logic [31:0] rvga_word;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - plain register with asynchronous active-high clear
module dff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // clear to zero on reset, otherwise follow d every rising edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q_o <= '0;
      else       q_o <= d_i;
   end

endmodule

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - counts consecutive data grants while fetch waits
module mem_arb_starve #(
   parameter int starve_limit_p = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic idle_i,
   input  logic if_req_i,
   input  logic dm_grant_i,
   input  logic if_grant_i,
   output logic starve_o
);

   localparam int CNT_W = ($clog2(starve_limit_p + 1) > 3) ? $clog2(starve_limit_p + 1) : 3;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(starve_limit_p);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // a fetch grant or an idle cycle with no fetch waiting restarts the count;
   // it saturates at the limit so the fetch stays favoured until served
   always_comb begin
      cnt_d = cnt_q;
      if (if_grant_i) begin
         cnt_d = '0;
      end else if (idle_i && !if_req_i) begin
         cnt_d = '0;
      end else if (dm_grant_i && if_req_i && (cnt_q < LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   dff #(.WIDTH(CNT_W)) u_cnt (.clk_i(clk_i), .rst_i(rst_i), .d_i(cnt_d), .q_o(cnt_q));

   assign starve_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data single-port memory arbiter (MEM_ARB_FAIR_EN adds fetch anti-starvation)
module mem_arbiter
   import rvga_types::*;
#(
   parameter int starve_limit_p = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       if_req_v_i,
   input  rvga_word   if_addr_i,
   output rvga_word   if_rdata_o,
   output logic       if_done_o,
   output logic       if_stall_v_o,
   input  logic       dm_req_v_i,
   input  logic       dm_we_i,
   input  logic [3:0] dm_wmask_i,
   input  rvga_word   dm_addr_i,
   input  rvga_word   dm_wdata_i,
   output rvga_word   dm_rdata_o,
   output logic       dm_done_o,
   output logic       mem_req_v_o,
   output logic       mem_we_o,
   output logic [3:0] mem_wmask_o,
   output rvga_word   mem_addr_o,
   output rvga_word   mem_wdata_o,
   input  rvga_word   mem_rdata_i,
   input  logic       mem_ack_i
);

   if (starve_limit_p < 1) begin : g_bad_limit
      $error("starve_limit_p must be at least 1");
   end

   logic [1:0] state_d, state_q;
   logic       mem_req_v_d, mem_req_v_q;
   logic       mem_we_d, mem_we_q;
   logic [3:0] mem_wmask_d, mem_wmask_q;
   rvga_word   mem_addr_d, mem_addr_q;
   rvga_word   mem_wdata_d, mem_wdata_q;

   logic idle, grant_dm, grant_if, fetch_force;

   assign idle = (state_q == IDLE);

`ifdef MEM_ARB_FAIR_EN
   logic starve;

   mem_arb_starve #(.starve_limit_p(starve_limit_p)) u_starve (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .idle_i     (idle),
      .if_req_i   (if_req_v_i),
      .dm_grant_i (grant_dm),
      .if_grant_i (grant_if),
      .starve_o   (starve)
   );

   assign fetch_force = starve & if_req_v_i;
`else
   assign fetch_force = 1'b0;
`endif

   assign grant_dm = idle & dm_req_v_i & ~fetch_force;
   assign grant_if = idle & if_req_v_i & (~dm_req_v_i | fetch_force);

   // arbitrate in IDLE, latch the winner's request, release on memory ack
   always_comb begin
      state_d     = state_q;
      mem_req_v_d = mem_req_v_q;
      mem_we_d    = mem_we_q;
      mem_wmask_d = mem_wmask_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_dm) begin
               state_d     = BUSY_DM;
               mem_req_v_d = 1'b1;
               mem_we_d    = dm_we_i;
               mem_wmask_d = dm_wmask_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
            end else if (grant_if) begin
               state_d     = BUSY_IF;
               mem_req_v_d = 1'b1;
               mem_we_d    = 1'b0;
               mem_wmask_d = 4'h0;
               mem_addr_d  = if_addr_i;
               mem_wdata_d = '0;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (mem_ack_i) begin
               state_d     = IDLE;
               mem_req_v_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_req_v_d = 1'b0;
         end
      endcase
   end

   dff #(.WIDTH(2))  u_state (.clk_i(clk_i), .rst_i(rst_i), .d_i(state_d),     .q_o(state_q));
   dff #(.WIDTH(1))  u_req_v (.clk_i(clk_i), .rst_i(rst_i), .d_i(mem_req_v_d), .q_o(mem_req_v_q));
   dff #(.WIDTH(1))  u_we    (.clk_i(clk_i), .rst_i(rst_i), .d_i(mem_we_d),    .q_o(mem_we_q));
   dff #(.WIDTH(4))  u_wmask (.clk_i(clk_i), .rst_i(rst_i), .d_i(mem_wmask_d), .q_o(mem_wmask_q));
   dff #(.WIDTH(32)) u_addr  (.clk_i(clk_i), .rst_i(rst_i), .d_i(mem_addr_d),  .q_o(mem_addr_q));
   dff #(.WIDTH(32)) u_wdata (.clk_i(clk_i), .rst_i(rst_i), .d_i(mem_wdata_d), .q_o(mem_wdata_q));

   assign mem_req_v_o = mem_req_v_q;
   assign mem_we_o    = mem_we_q;
   assign mem_wmask_o = mem_wmask_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   // completion is combinational on ack; reset clears state so no pulse escapes
   assign if_done_o    = (state_q == BUSY_IF) & mem_ack_i & ~rst_i;
   assign dm_done_o    = (state_q == BUSY_DM) & mem_ack_i & ~rst_i;
   assign if_rdata_o   = if_done_o ? mem_rdata_i : '0;
   assign dm_rdata_o   = (dm_done_o & ~mem_we_q) ? mem_rdata_i : '0;
   assign if_stall_v_o = if_req_v_i & ~if_done_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_v_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_done_o;
   logic        if_stall_v_o;
   logic        dm_req_v_i;
   logic        dm_we_i;
   logic [3:0]  dm_wmask_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic [31:0] dm_rdata_o;
   logic        dm_done_o;
   logic        mem_req_v_o;
   logic        mem_we_o;
   logic [3:0]  mem_wmask_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.starve_limit_p(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .if_req_v_i   (if_req_v_i),
      .if_addr_i    (if_addr_i),
      .if_rdata_o   (if_rdata_o),
      .if_done_o    (if_done_o),
      .if_stall_v_o (if_stall_v_o),
      .dm_req_v_i   (dm_req_v_i),
      .dm_we_i      (dm_we_i),
      .dm_wmask_i   (dm_wmask_i),
      .dm_addr_i    (dm_addr_i),
      .dm_wdata_i   (dm_wdata_i),
      .dm_rdata_o   (dm_rdata_o),
      .dm_done_o    (dm_done_o),
      .mem_req_v_o  (mem_req_v_o),
      .mem_we_o     (mem_we_o),
      .mem_wmask_o  (mem_wmask_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge; inputs are driven here
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   int  dm_grants;
   bit  if_seen;

   initial begin
      rst_i = 1'b1; if_req_v_i = 0; if_addr_i = 0; dm_req_v_i = 0; dm_we_i = 0;
      dm_wmask_i = 0; dm_addr_i = 0; dm_wdata_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
      #3;
      mem_ack_i = 1'b1; dm_req_v_i = 1'b1; mem_rdata_i = 32'h5555_5555;
      settle();
      check("rst_req_v", {31'd0, mem_req_v_o}, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_wmask", {28'd0, mem_wmask_o}, 0);
      check("rst_dm_done", {31'd0, dm_done_o}, 0);
      check("rst_dm_rdata", dm_rdata_o, 0);
      tick();
      check("rst_hold_req_v", {31'd0, mem_req_v_o}, 0);
      mem_ack_i = 0; dm_req_v_i = 0; mem_rdata_i = 0;
      rst_i = 1'b0;

      // fetch only, ack two cycles after mem_req_v_o
      tick();
      if_req_v_i = 1; if_addr_i = 32'h100;
      settle();
      check("f_stall0", {31'd0, if_stall_v_o}, 1);
      check("f_req_v0", {31'd0, mem_req_v_o}, 0);
      tick();
      if_addr_i = 32'h999;
      settle();
      check("f_req_v1", {31'd0, mem_req_v_o}, 1);
      check("f_addr", mem_addr_o, 32'h100);
      check("f_we", {31'd0, mem_we_o}, 0);
      check("f_done1", {31'd0, if_done_o}, 0);
      check("f_stall1", {31'd0, if_stall_v_o}, 1);
      tick();
      settle();
      check("f_addr_hold", mem_addr_o, 32'h100);
      check("f_done2", {31'd0, if_done_o}, 0);
      check("f_rdata_idle", if_rdata_o, 0);
      tick();
      mem_ack_i = 1; mem_rdata_i = 32'h0000_0013;
      settle();
      check("f_done3", {31'd0, if_done_o}, 1);
      check("f_rdata", if_rdata_o, 32'h13);
      check("f_stall3", {31'd0, if_stall_v_o}, 0);
      check("f_dm_done", {31'd0, dm_done_o}, 0);
      tick();
      mem_ack_i = 0; if_req_v_i = 0; mem_rdata_i = 0;
      settle();
      check("f_done_pulse", {31'd0, if_done_o}, 0);
      check("f_req_v_off", {31'd0, mem_req_v_o}, 0);

      // simultaneous: data write first, then fetch after one idle cycle
      tick();
      if_req_v_i = 1; if_addr_i = 32'h104;
      dm_req_v_i = 1; dm_we_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD_BEEF; dm_wmask_i = 4'hF;
      tick();
      dm_addr_i = 32'h300; dm_wdata_i = 32'h1;
      settle();
      check("s_req_v", {31'd0, mem_req_v_o}, 1);
      check("s_we", {31'd0, mem_we_o}, 1);
      check("s_addr", mem_addr_o, 32'h200);
      check("s_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      check("s_wmask", {28'd0, mem_wmask_o}, 32'hF);
      mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D;
      settle();
      check("s_dm_done", {31'd0, dm_done_o}, 1);
      check("s_dm_rdata_wr", dm_rdata_o, 0);
      check("s_if_done", {31'd0, if_done_o}, 0);
      check("s_if_stall", {31'd0, if_stall_v_o}, 1);
      tick();
      mem_ack_i = 0; dm_req_v_i = 0; dm_we_i = 0;
      settle();
      check("s_idle_gap", {31'd0, mem_req_v_o}, 0);
      tick();
      settle();
      check("s_f_req_v", {31'd0, mem_req_v_o}, 1);
      check("s_f_addr", mem_addr_o, 32'h104);
      check("s_f_we", {31'd0, mem_we_o}, 0);
      check("s_f_wmask", {28'd0, mem_wmask_o}, 0);
      mem_ack_i = 1; mem_rdata_i = 32'h0000_0093;
      settle();
      check("s_f_done", {31'd0, if_done_o}, 1);
      check("s_f_rdata", if_rdata_o, 32'h93);
      tick();
      mem_ack_i = 0; if_req_v_i = 0; mem_rdata_i = 0;

      // data read returns rdata
      tick();
      dm_req_v_i = 1; dm_we_i = 0; dm_addr_i = 32'h40;
      tick();
      mem_ack_i = 1; mem_rdata_i = 32'h1234_5678;
      settle();
      check("r_dm_done", {31'd0, dm_done_o}, 1);
      check("r_dm_rdata", dm_rdata_o, 32'h1234_5678);
      tick();
      mem_ack_i = 0; dm_req_v_i = 0; mem_rdata_i = 0;

      // continuous data plus fetch requests, ack every busy cycle
      tick();
      dm_req_v_i = 1; dm_we_i = 0; dm_addr_i = 32'h80; if_req_v_i = 1; if_addr_i = 32'h108;
      dm_grants = 0; if_seen = 0;
      for (int k = 0; k < 40 && !if_seen; k++) begin
         tick();
         mem_ack_i = mem_req_v_o;
         settle();
         if (dm_done_o) dm_grants++;
         if (if_done_o) if_seen = 1;
      end
      mem_ack_i = 0; dm_req_v_i = 0; if_req_v_i = 0;
`ifdef MEM_ARB_FAIR_EN
      check("fair_if_seen", {31'd0, if_seen}, 1);
      check("fair_dm_grants", dm_grants, 4);
`else
      check("prio_if_seen", {31'd0, if_seen}, 0);
      check("prio_dm_grants", dm_grants, 20);
`endif
      tick();
      tick();

      // reset in the middle of a data access
      dm_req_v_i = 1; dm_we_i = 0; dm_addr_i = 32'h44;
      tick();
      settle();
      check("m_req_v", {31'd0, mem_req_v_o}, 1);
      rst_i = 1;
      settle();
      check("m_rst_req_v", {31'd0, mem_req_v_o}, 0);
      check("m_rst_addr", mem_addr_o, 0);
      tick();
      rst_i = 0; dm_req_v_i = 0;
      tick();
      mem_ack_i = 1; mem_rdata_i = 32'hAAAA_0000;
      settle();
      check("m_late_ack_done", {31'd0, dm_done_o}, 0);
      check("m_late_ack_rdata", dm_rdata_o, 0);

      // stray ack in idle
      tick();
      settle();
      check("x_if_done", {31'd0, if_done_o}, 0);
      check("x_dm_done", {31'd0, dm_done_o}, 0);
      check("x_req_v", {31'd0, mem_req_v_o}, 0);
      mem_ack_i = 0;
      if_req_v_i = 1; if_addr_i = 32'h200;
      tick();
      settle();
      check("x_still_idle", {31'd0, mem_req_v_o}, 1);
      check("x_addr", mem_addr_o, 32'h200);
      mem_ack_i = 1;
      settle();
      check("x_done_after", {31'd0, if_done_o}, 1);
      tick();
      mem_ack_i = 0; if_req_v_i = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
